// File: rtl/elastic_fifo_if.sv
// Valid/ready stream bundle for elastic_fifo: producer side (in_*) and
// consumer side (out_*). The FIFO uses the slave modport; the environment
// driving and consuming the stream uses master.
interface elastic_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_data_o;

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/elastic_fifo.sv
// DEPTH-entry valid/ready elastic FIFO with optional registered output stage,
// synchronous flush and occupancy reporting. in_ready_o and out_valid_o come
// only from registered state, so neither handshake side sees a combinational
// path from the other.
// Optional macro ELASTIC_FIFO_STATS_EN: enables the saturating 16-bit
// consumer-stall counter on out_stall_cnt_o (tied to zero otherwise).
module elastic_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int REG_OUTPUT = 1,
  parameter int CNT_W      = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  elastic_fifo_if.slave    bus,
  output logic [CNT_W-1:0] count_o,
  output logic [15:0]      out_stall_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CAP   = DEPTH + REG_OUTPUT;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      ram_cnt_q, ram_cnt_d;
  logic [CNT_W-1:0]      count_d;
  logic                  in_ready_q, in_ready_d;

  logic                  push;
  logic                  pop;
  logic                  ram_wr;
  logic                  ram_rd;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  oreg_vld;
  logic                  oreg_vld_d;

  assign push = bus.in_valid_i & in_ready_q;
  assign pop  = out_valid & bus.out_ready_i;

  if (REG_OUTPUT != 0) begin : g_oreg
    logic                  oreg_vld_q;
    logic [DATA_WIDTH-1:0] oreg_data_q, oreg_data_d;
    logic                  oreg_free;
    logic                  bypass;

    // Output-stage steering: refill from RAM head when free, or take the
    // incoming item directly when the RAM is empty.
    always_comb begin
      oreg_free   = ~oreg_vld_q | pop;
      ram_rd      = oreg_free & (ram_cnt_q != '0);
      bypass      = oreg_free & (ram_cnt_q == '0) & push;
      ram_wr      = push & ~bypass;
      oreg_vld_d  = oreg_vld_q;
      oreg_data_d = oreg_data_q;
      if (ram_rd) begin
        oreg_vld_d  = 1'b1;
        oreg_data_d = mem_q[rd_ptr_q];
      end else if (bypass) begin
        oreg_vld_d  = 1'b1;
        oreg_data_d = bus.in_data_i;
      end else if (oreg_free) begin
        oreg_vld_d  = 1'b0;
      end
      if (flush_i) begin
        oreg_vld_d = 1'b0;
      end
    end

    // Output register; data cleared on reset so nothing X reaches consumers.
    always_ff @(posedge clk) begin
      if (rst) begin
        oreg_vld_q  <= 1'b0;
        oreg_data_q <= '0;
      end else begin
        oreg_vld_q  <= oreg_vld_d;
        oreg_data_q <= oreg_data_d;
      end
    end

    assign oreg_vld  = oreg_vld_q;
    assign out_valid = oreg_vld_q;
    assign out_data  = oreg_data_q;
  end else begin : g_noreg
    assign ram_rd     = pop;
    assign ram_wr     = push;
    assign oreg_vld   = 1'b0;
    assign oreg_vld_d = 1'b0;
    assign out_valid  = (ram_cnt_q != '0);
    assign out_data   = mem_q[rd_ptr_q];
  end

  // Pointer/occupancy next state; flush discards this cycle's handshakes.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    ram_cnt_d = ram_cnt_q;
    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      ram_cnt_d = '0;
    end else begin
      if (ram_wr) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (ram_rd) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      ram_cnt_d = ram_cnt_q + CNT_W'(ram_wr) - CNT_W'(ram_rd);
    end
    count_d    = ram_cnt_d + CNT_W'(oreg_vld_d);
    in_ready_d = (count_d < CNT_W'(CAP));
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Storage array; left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (ram_wr && !flush_i) begin
      mem_q[wr_ptr_q] <= bus.in_data_i;
    end
  end

`ifdef ELASTIC_FIFO_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of edges where the consumer held off a valid item.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !bus.out_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register; only reset clears it, flush does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_stall_cnt_o = stall_cnt_q;
`else
  assign out_stall_cnt_o = '0;
`endif

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = out_data;
  assign count_o         = ram_cnt_q + CNT_W'(oreg_vld);

endmodule
